maxpool_2x2_8ch: RTL and testbench

Streaming 2×2 stride-2 max-pooling stage for eight parallel IEEE-754 single-precision feature-map channels. It sits at the tail of a VGG16 conv block: it consumes the raster-ordered 8-channel pixel stream from the convolution/ReLU stage and produces the pooled 8-channel stream that feeds the next layer or the 3-D result writer in simulation. It has no backpressure; it accepts one pixel per cycle whenever `data_valid_in` is high.

---
 rtl/maxpool_2x2_8ch.sv | 174 +++++++++++++++++
 tb/tb_maxpool_2x2_8ch.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_2x2_8ch.sv
// Streaming 2x2 stride-2 max-pool over eight IEEE-754 single channels, raster input, no backpressure.
// Optional fused ReLU on the pooled result: define MAXPOOL_RELU_EN.
module maxpool_2x2_8ch #(
    parameter int DWIDTH = 32,
    parameter int WIDTH  = 56,
    parameter int HEIGHT = 56
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DWIDTH-1:0] data_in_0,
    input  logic [DWIDTH-1:0] data_in_1,
    input  logic [DWIDTH-1:0] data_in_2,
    input  logic [DWIDTH-1:0] data_in_3,
    input  logic [DWIDTH-1:0] data_in_4,
    input  logic [DWIDTH-1:0] data_in_5,
    input  logic [DWIDTH-1:0] data_in_6,
    input  logic [DWIDTH-1:0] data_in_7,
    input  logic              data_valid_in,
    output logic [DWIDTH-1:0] data_out_0,
    output logic [DWIDTH-1:0] data_out_1,
    output logic [DWIDTH-1:0] data_out_2,
    output logic [DWIDTH-1:0] data_out_3,
    output logic [DWIDTH-1:0] data_out_4,
    output logic [DWIDTH-1:0] data_out_5,
    output logic [DWIDTH-1:0] data_out_6,
    output logic [DWIDTH-1:0] data_out_7,
    output logic              data_valid_out,
    output logic              frame_done,
    output logic              o_state
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int LD = WIDTH / 2;
    localparam int LW = (LD > 1) ? $clog2(LD) : 1;

    typedef enum logic {
        S_EVEN = 1'b0,
        S_ODD  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_lb_wr;
    logic              w_emit;
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic              w_col_last;
    logic              w_row_last;
    logic [LW-1:0]     w_lidx;
    logic              r_vout;
    logic              r_fdone;

    logic [DWIDTH-1:0] w_din  [8];
    logic [DWIDTH-1:0] r_hold [8];
    logic [DWIDTH-1:0] w_hmax [8];
    logic [DWIDTH-1:0] w_pool [8];
    logic [DWIDTH-1:0] r_dout [8];
    logic [DWIDTH-1:0] r_lbuf [LD][8];

    // Sign-magnitude ordering; -0 versus +0 resolves to +0 because the sign test comes first.
    function automatic logic [DWIDTH-1:0] fmax(input logic [DWIDTH-1:0] a, input logic [DWIDTH-1:0] b);
        if (a[DWIDTH-1] != b[DWIDTH-1])
            return a[DWIDTH-1] ? b : a;
        else if (!a[DWIDTH-1])
            return (b[DWIDTH-2:0] > a[DWIDTH-2:0]) ? b : a;
        else
            return (b[DWIDTH-2:0] < a[DWIDTH-2:0]) ? b : a;
    endfunction

    assign w_din[0] = data_in_0;
    assign w_din[1] = data_in_1;
    assign w_din[2] = data_in_2;
    assign w_din[3] = data_in_3;
    assign w_din[4] = data_in_4;
    assign w_din[5] = data_in_5;
    assign w_din[6] = data_in_6;
    assign w_din[7] = data_in_7;

    assign w_col_last = (r_col == CW'(WIDTH - 1));
    assign w_row_last = (r_row == RW'(HEIGHT - 1));
    assign w_lidx     = LW'(r_col >> 1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= S_EVEN;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lb_wr     = 1'b0;
        w_emit      = 1'b0;
        case (r_state)
            S_EVEN: begin
                w_lb_wr = data_valid_in && r_col[0];
                if (data_valid_in && w_col_last)
                    w_state_nxt = S_ODD;
            end
            S_ODD: begin
                w_emit = data_valid_in && r_col[0];
                if (data_valid_in && w_col_last)
                    w_state_nxt = S_EVEN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_col <= '0;
            r_row <= '0;
        end else if (data_valid_in) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_hmax[k] = fmax(r_hold[k], w_din[k]);
            w_pool[k] = fmax(r_lbuf[w_lidx][k], w_hmax[k]);
`ifdef MAXPOOL_RELU_EN
            if (w_pool[k][DWIDTH-1])
                w_pool[k] = '0;
`endif
        end
    end

    // Line buffer is written before every read within a frame, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_lb_wr) begin
            for (int k = 0; k < 8; k++)
                r_lbuf[w_lidx][k] <= w_hmax[k];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < 8; k++) begin
                r_hold[k] <= '0;
                r_dout[k] <= '0;
            end
            r_vout  <= 1'b0;
            r_fdone <= 1'b0;
        end else begin
            r_vout  <= w_emit;
            r_fdone <= w_emit && w_row_last && w_col_last;
            for (int k = 0; k < 8; k++) begin
                if (data_valid_in && !r_col[0])
                    r_hold[k] <= w_din[k];
                if (w_emit)
                    r_dout[k] <= w_pool[k];
            end
        end
    end

    assign data_out_0     = r_dout[0];
    assign data_out_1     = r_dout[1];
    assign data_out_2     = r_dout[2];
    assign data_out_3     = r_dout[3];
    assign data_out_4     = r_dout[4];
    assign data_out_5     = r_dout[5];
    assign data_out_6     = r_dout[6];
    assign data_out_7     = r_dout[7];
    assign data_valid_out = r_vout;
    assign frame_done     = r_fdone;
    assign o_state        = r_state;

endmodule

// File: tb/tb_maxpool_2x2_8ch.sv
// Bench for maxpool_2x2_8ch on a 4x4 frame: directed scenarios with random data against a window-max model.
module tb_maxpool_2x2_8ch;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int EW = 257;

    logic        clk;
    logic        resetn;
    logic        valid_in;
    logic [31:0] din  [8];
    logic [31:0] dout [8];
    logic        data_valid_out;
    logic        frame_done;
    logic        dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fd_count = 0;

    logic [EW-1:0] exp_q[$];
    int            due_q[$];
    logic [EW-1:0] out_log[$];
    logic [EW-1:0] log1[$];
    logic [31:0]   frm [H][W][8];

    maxpool_2x2_8ch #(.DWIDTH(32), .WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .resetn(resetn),
        .data_in_0(din[0]), .data_in_1(din[1]), .data_in_2(din[2]), .data_in_3(din[3]),
        .data_in_4(din[4]), .data_in_5(din[5]), .data_in_6(din[6]), .data_in_7(din[7]),
        .data_valid_in(valid_in),
        .data_out_0(dout[0]), .data_out_1(dout[1]), .data_out_2(dout[2]), .data_out_3(dout[3]),
        .data_out_4(dout[4]), .data_out_5(dout[5]), .data_out_6(dout[6]), .data_out_7(dout[7]),
        .data_valid_out(data_valid_out), .frame_done(frame_done), .o_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] cur_out();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = dout[k];
        return r;
    endfunction

    // reference model: real-number ordering of floats, +0 preferred over -0
    function automatic int fkey(input logic [31:0] a);
        return a[31] ? -int'({1'b0, a[30:0]}) : int'({1'b0, a[30:0]});
    endfunction

    function automatic logic [31:0] ref_pool(input logic [31:0] a, b, c, d);
        logic [31:0] v[4];
        logic [31:0] best;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        best = v[0];
        for (int i = 1; i < 4; i++)
            if (fkey(v[i]) > fkey(best) || (fkey(v[i]) == fkey(best) && best[31] && !v[i][31]))
                best = v[i];
`ifdef MAXPOOL_RELU_EN
        if (best[31]) best = 32'h0;
`endif
        return best;
    endfunction

    function automatic logic [31:0] i2f(input int n);
        int e = 0;
        logic [31:0] m;
        if (n == 0) return 32'h0;
        for (int i = 0; i < 31; i++) if ((n >> i) != 0) e = i;
        m = (32'(n) << (23 - e)) & 32'h007F_FFFF;
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    function automatic logic [31:0] rand_float();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)), 23'($urandom)};
    endfunction

    task automatic fill_seq();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                for (int k = 0; k < 8; k++) frm[r][c][k] = i2f(r * 4 + c + k);
    endtask

    task automatic fill_rand();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                for (int k = 0; k < 8; k++) frm[r][c][k] = rand_float();
    endtask

    // driver tasks (called aligned to a falling edge)
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            valid_in = 1'b0;
            for (int k = 0; k < 8; k++) din[k] = $urandom;
            @(negedge clk);
        end
    endtask

    task automatic drive_pix(input int r, input int c);
        logic [EW-1:0] e;
        valid_in = 1'b1;
        for (int k = 0; k < 8; k++) din[k] = frm[r][c][k];
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            e = '0;
            for (int k = 0; k < 8; k++)
                e[k*32 +: 32] = ref_pool(frm[r-1][c-1][k], frm[r-1][c][k], frm[r][c-1][k], frm[r][c][k]);
            e[256] = (r == H - 1) && (c == W - 1);
            exp_q.push_back(e);
            due_q.push_back(cyc + 1);
        end
        @(negedge clk);
    endtask

    task automatic run_frame(input bit gaps, input int npix);
        int n = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (n < npix) begin
                    if (gaps) while ($urandom_range(0, 1) == 1) idle(1);
                    drive_pix(r, c);
                    n++;
                end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            idle(1);
            n++;
        end
        check("drain_pending", EW'(exp_q.size()), EW'(0));
        idle(2);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, EW'(data_valid_out), EW'(0));
        check({tag, "_frame_done"}, EW'(frame_done), EW'(0));
        check({tag, "_data"}, EW'(cur_out()), EW'(0));
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        valid_in = 1'b0;
        #2;
        check_reset_values("reset_mid");
        exp_q.delete();
        due_q.delete();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (data_valid_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", EW'(data_valid_out), EW'(0));
                end else begin
                    check("out_data", {frame_done, cur_out()}, exp_q.pop_front());
                    check("out_latency", EW'(cyc), EW'(due_q.pop_front()));
                    out_log.push_back({frame_done, cur_out()});
                    if (frame_done === 1'b1) fd_count++;
                end
            end else begin
                check("frame_done_alone", EW'(frame_done), EW'(0));
                if (due_q.size() > 0 && due_q[0] <= cyc) begin
                    check("missed_out", EW'(data_valid_out), EW'(1));
                    void'(exp_q.pop_front());
                    void'(due_q.pop_front());
                end
            end
        end
    end

    initial begin
        void'($urandom(32'd2024));
        resetn   = 1'b0;
        valid_in = 1'b0;
        for (int k = 0; k < 8; k++) din[k] = '0;
        #1;
        check_reset_values("reset_initial");
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // ascending frame, continuous valid
        fill_seq();
        fd_count = 0;
        run_frame(1'b0, 16);
        drain();
        check("seq_count", EW'(out_log.size()), EW'(4));
        check("seq_ch0_o0", EW'(out_log[0][31:0]), EW'(32'h40A0_0000));
        check("seq_ch0_o1", EW'(out_log[1][31:0]), EW'(32'h40E0_0000));
        check("seq_ch0_o2", EW'(out_log[2][31:0]), EW'(32'h4150_0000));
        check("seq_ch0_o3", EW'(out_log[3][31:0]), EW'(32'h4170_0000));
        check("seq_fd_o3", EW'(out_log[3][256]), EW'(1));
        check("seq_fd_count", EW'(fd_count), EW'(1));
        check("idle_valid", EW'(data_valid_out), EW'(0));
        check("idle_hold", EW'(cur_out()), EW'(out_log[3][255:0]));
        log1 = out_log;
        out_log.delete();

        // negative and signed-zero windows in channel 0
        fill_rand();
        frm[0][0][0] = 32'hBF80_0000; frm[0][1][0] = 32'hC000_0000;
        frm[1][0][0] = 32'hBF00_0000; frm[1][1][0] = 32'hC040_0000;
        frm[0][2][0] = 32'h8000_0000; frm[0][3][0] = 32'h0000_0000;
        frm[1][2][0] = 32'hBF80_0000; frm[1][3][0] = 32'hC000_0000;
        run_frame(1'b0, 16);
        drain();
`ifdef MAXPOOL_RELU_EN
        check("sign_neg_window", EW'(out_log[0][31:0]), EW'(32'h0000_0000));
`else
        check("sign_neg_window", EW'(out_log[0][31:0]), EW'(32'hBF00_0000));
`endif
        check("sign_zero_window", EW'(out_log[1][31:0]), EW'(32'h0000_0000));
        out_log.delete();

        // same ascending frame with random idle gaps
        fill_seq();
        run_frame(1'b1, 16);
        drain();
        check("gap_count", EW'(out_log.size()), EW'(4));
        for (int i = 0; i < 4; i++) check("gap_vs_nogap", out_log[i], log1[i]);
        out_log.delete();

        // back-to-back frames, second with random data
        fd_count = 0;
        fill_seq();
        run_frame(1'b0, 16);
        fill_rand();
        run_frame(1'b0, 16);
        drain();
        check("b2b_count", EW'(out_log.size()), EW'(8));
        check("b2b_fd_o3", EW'(out_log[3][256]), EW'(1));
        check("b2b_fd_o7", EW'(out_log[7][256]), EW'(1));
        check("b2b_fd_count", EW'(fd_count), EW'(2));
        out_log.delete();

        // reset pulse mid-frame, then a clean frame
        fill_rand();
        run_frame(1'b0, 6);
        idle(2);
        out_log.delete();
        do_reset();
        idle(1);
        fill_seq();
        run_frame(1'b0, 16);
        drain();
        check("rst_count", EW'(out_log.size()), EW'(4));
        for (int i = 0; i < 4; i++) check("rst_vs_first", out_log[i], log1[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
